// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: bus widths, write-enable levels and the
// lane / late-result record layouts used by wb_stage and its late queue.
package wb_stage_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned RegAddrBus  = 5;
  localparam int unsigned RegBus      = 32;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  // One registered memory-stage lane.
  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [InstAddrBus-1:0] pc;
    logic [RegAddrBus-1:0]  waddr;
    logic [RegBus-1:0]      wdata;
  } lane_t;

  // One long-latency result as stored in the late queue.
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [RegAddrBus-1:0]  waddr;
    logic [RegBus-1:0]      wdata;
  } late_t;

  localparam int unsigned LateWidth = $bits(late_t);

  // Builds the next lane register value; a flush turns the lane into a bubble
  // that neither writes nor counts as retired.
  function automatic lane_t lane_capture(input logic                   valid,
                                         input logic                   we,
                                         input logic [InstAddrBus-1:0] pc,
                                         input logic [RegAddrBus-1:0]  waddr,
                                         input logic [RegBus-1:0]      wdata,
                                         input logic                   flush);
    lane_t l;
    l.valid = valid & ~flush;
    l.we    = valid & we & (waddr != '0) & ~flush;
    l.pc    = pc;
    l.waddr = waddr;
    l.wdata = wdata;
    return l;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count. DEPTH must be a power of
// two so the read/write pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Qualify requests against the registered state so overflow/underflow is impossible.
  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rdata   = mem_q[rd_ptr_q];
    count   = count_q;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_stage.sv
// Dual-lane write-back stage. Registers both memory-stage lanes and slips
// queued long-latency (divider) results into whichever register-file port
// the lanes leave idle, lane 1 first, at most one per cycle.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   valid_i_1,
  input  logic [InstAddrBus-1:0] pc_i_1,
  input  logic                   we_i_1,
  input  logic [RegAddrBus-1:0]  waddr_i_1,
  input  logic [RegBus-1:0]      wdata_i_1,

  input  logic                   valid_i_2,
  input  logic [InstAddrBus-1:0] pc_i_2,
  input  logic                   we_i_2,
  input  logic [RegAddrBus-1:0]  waddr_i_2,
  input  logic [RegBus-1:0]      wdata_i_2,

  input  logic                   flush,

  input  logic                   late_valid,
  input  logic [InstAddrBus-1:0] late_pc,
  input  logic [RegAddrBus-1:0]  late_waddr,
  input  logic [RegBus-1:0]      late_wdata,
  output logic                   late_ready,

  output logic [InstAddrBus-1:0] pc_o_1,
  output logic                   we_o_1,
  output logic [RegAddrBus-1:0]  waddr_o_1,
  output logic [RegBus-1:0]      wdata_o_1,

  output logic [InstAddrBus-1:0] pc_o_2,
  output logic                   we_o_2,
  output logic [RegAddrBus-1:0]  waddr_o_2,
  output logic [RegBus-1:0]      wdata_o_2,

  output logic [1:0]             late_cnt,
  output logic [31:0]            commit_cnt
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  lane_t lane1_d, lane1_q, lane2_d, lane2_q;
  late_t late_in, late_head;
  logic  q_push, q_pop, q_full, q_empty;
  logic [CntW-1:0] q_count;
  logic [31:0] commit_q;

  // Next lane values, flush applied.
  always_comb begin
    lane1_d = lane_capture(valid_i_1, we_i_1, pc_i_1, waddr_i_1, wdata_i_1, flush);
    lane2_d = lane_capture(valid_i_2, we_i_2, pc_i_2, waddr_i_2, wdata_i_2, flush);
  end

  // Lane registers and retired-lane counter; the counter already includes the
  // lanes currently held in the lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane1_q  <= '0;
      lane2_q  <= '0;
      commit_q <= '0;
    end else begin
      lane1_q  <= lane1_d;
      lane2_q  <= lane2_d;
      commit_q <= commit_q + 32'(lane1_d.valid) + 32'(lane2_d.valid);
    end
  end

  // Results targeting r0 are accepted but never queued.
  always_comb begin
    late_in.pc    = late_pc;
    late_in.waddr = late_waddr;
    late_in.wdata = late_wdata;
    q_push        = late_valid & late_ready & (late_waddr != '0);
  end

  sync_fifo #(
    .WIDTH (LateWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_late_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (late_in),
    .pop   (q_pop),
    .rdata (late_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Port muxing: registered lanes first, queue head fills the first idle port.
  // Only registered state feeds this, so a push never bypasses to the outputs.
  always_comb begin
    q_pop     = 1'b0;
    we_o_1    = WriteDisable;
    pc_o_1    = ZeroWord;
    waddr_o_1 = '0;
    wdata_o_1 = ZeroWord;
    we_o_2    = WriteDisable;
    pc_o_2    = ZeroWord;
    waddr_o_2 = '0;
    wdata_o_2 = ZeroWord;

    if (lane1_q.we) begin
      we_o_1    = WriteEnable;
      pc_o_1    = lane1_q.pc;
      waddr_o_1 = lane1_q.waddr;
      wdata_o_1 = lane1_q.wdata;
    end
    if (lane2_q.we) begin
      we_o_2    = WriteEnable;
      pc_o_2    = lane2_q.pc;
      waddr_o_2 = lane2_q.waddr;
      wdata_o_2 = lane2_q.wdata;
    end

    if (!q_empty) begin
      if (!lane1_q.we) begin
        q_pop     = 1'b1;
        we_o_1    = WriteEnable;
        pc_o_1    = late_head.pc;
        waddr_o_1 = late_head.waddr;
        wdata_o_1 = late_head.wdata;
      end else if (!lane2_q.we) begin
        q_pop     = 1'b1;
        we_o_2    = WriteEnable;
        pc_o_2    = late_head.pc;
        waddr_o_2 = late_head.waddr;
        wdata_o_2 = late_head.wdata;
      end
    end
  end

  // Status outputs; readiness comes from the registered count only.
  always_comb begin
    late_ready = ~q_full;
    late_cnt   = q_count[1:0];
    commit_cnt = commit_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i_1, we_i_1, valid_i_2, we_i_2;
  logic [31:0] pc_i_1, wdata_i_1, pc_i_2, wdata_i_2;
  logic [4:0]  waddr_i_1, waddr_i_2;
  logic        flush;
  logic        late_valid;
  logic [31:0] late_pc, late_wdata;
  logic [4:0]  late_waddr;
  logic        late_ready;
  logic [31:0] pc_o_1, wdata_o_1, pc_o_2, wdata_o_2;
  logic        we_o_1, we_o_2;
  logic [4:0]  waddr_o_1, waddr_o_2;
  logic [1:0]  late_cnt;
  logic [31:0] commit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i_1  (valid_i_1),
    .pc_i_1     (pc_i_1),
    .we_i_1     (we_i_1),
    .waddr_i_1  (waddr_i_1),
    .wdata_i_1  (wdata_i_1),
    .valid_i_2  (valid_i_2),
    .pc_i_2     (pc_i_2),
    .we_i_2     (we_i_2),
    .waddr_i_2  (waddr_i_2),
    .wdata_i_2  (wdata_i_2),
    .flush      (flush),
    .late_valid (late_valid),
    .late_pc    (late_pc),
    .late_waddr (late_waddr),
    .late_wdata (late_wdata),
    .late_ready (late_ready),
    .pc_o_1     (pc_o_1),
    .we_o_1     (we_o_1),
    .waddr_o_1  (waddr_o_1),
    .wdata_o_1  (wdata_o_1),
    .pc_o_2     (pc_o_2),
    .we_o_2     (we_o_2),
    .waddr_o_2  (waddr_o_2),
    .wdata_o_2  (wdata_o_2),
    .late_cnt   (late_cnt),
    .commit_cnt (commit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One rising edge; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lane1(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    valid_i_1 = v; we_i_1 = 1'b1; waddr_i_1 = a; wdata_i_1 = d; pc_i_1 = pc;
  endtask

  task automatic lane2(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    valid_i_2 = v; we_i_2 = 1'b1; waddr_i_2 = a; wdata_i_2 = d; pc_i_2 = pc;
  endtask

  task automatic late(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] pc);
    late_valid = v; late_waddr = a; late_wdata = d; late_pc = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    lane1(0, 0, 0, 0); lane2(0, 0, 0, 0); late(0, 0, 0, 0);
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_we1", we_o_1, 0);
    check("rst_we2", we_o_2, 0);
    check("rst_pc1", pc_o_1, 0);
    check("rst_cnt", late_cnt, 0);
    check("rst_rdy", late_ready, 1);
    check("rst_commit", commit_cnt, 0);

    // Lane 1 writes r3, lane 2 targets r0
    lane1(1, 3, 32'hAA, 32'h1c00_0000); lane2(1, 0, 32'hBB, 32'h1c00_0004);
    step();
    check("l1_we1", we_o_1, 1);
    check("l1_waddr1", waddr_o_1, 3);
    check("l1_wdata1", wdata_o_1, 32'hAA);
    check("l1_pc1", pc_o_1, 32'h1c00_0000);
    check("l1_we2", we_o_2, 0);
    check("l1_pc2", pc_o_2, 0);
    check("l1_commit", commit_cnt, 2);
    lane1(0, 0, 0, 0); lane2(0, 0, 0, 0);
    step();
    check("idle_we1", we_o_1, 0);
    check("idle_commit", commit_cnt, 2);

    // Flush both valid lanes
    lane1(1, 1, 32'h11, 32'h100); lane2(1, 2, 32'h22, 32'h104); flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_we1", we_o_1, 0);
    check("fl_we2", we_o_2, 0);
    check("fl_waddr1", waddr_o_1, 0);
    check("fl_commit", commit_cnt, 2);

    // Late result held while both lanes write, then slips into lane 1
    late(1, 5, 32'h55, 32'h200);
    step();
    late(0, 0, 0, 0);
    check("hold_cnt", late_cnt, 1);
    check("hold_waddr1", waddr_o_1, 1);
    check("hold_commit", commit_cnt, 4);
    step();
    check("hold2_cnt", late_cnt, 1);
    check("hold2_commit", commit_cnt, 6);
    lane1(0, 0, 0, 0);
    step();
    check("slip_we1", we_o_1, 1);
    check("slip_waddr1", waddr_o_1, 5);
    check("slip_wdata1", wdata_o_1, 32'h55);
    check("slip_pc1", pc_o_1, 32'h200);
    check("slip_waddr2", waddr_o_2, 2);
    check("slip_commit", commit_cnt, 7);
    lane2(0, 0, 0, 0);
    step();
    check("slip_cnt0", late_cnt, 0);
    check("slip_we1_off", we_o_1, 0);
    check("slip_we2_off", we_o_2, 0);

    // Three back-to-back pushes with both lanes busy
    lane1(1, 1, 32'h11, 32'h100); lane2(1, 2, 32'h22, 32'h104);
    late(1, 6, 32'h61, 32'h300);
    step();
    check("b2b_cnt1", late_cnt, 1);
    check("b2b_rdy1", late_ready, 1);
    late(1, 7, 32'h62, 32'h304);
    step();
    check("b2b_cnt2", late_cnt, 2);
    check("b2b_rdy2", late_ready, 0);
    late(1, 8, 32'h63, 32'h308);
    step();
    check("b2b_held_cnt", late_cnt, 2);
    check("b2b_held_rdy", late_ready, 0);
    check("b2b_lane_waddr1", waddr_o_1, 1);
    lane1(0, 0, 0, 0);
    step();
    check("drain1_waddr1", waddr_o_1, 6);
    check("drain1_wdata1", wdata_o_1, 32'h61);
    check("drain1_waddr2", waddr_o_2, 2);
    check("drain1_rdy", late_ready, 0);
    step();
    check("drain2_waddr1", waddr_o_1, 7);
    check("drain2_cnt", late_cnt, 1);
    check("drain2_rdy", late_ready, 1);
    step();
    late(0, 0, 0, 0);
    check("drain3_waddr1", waddr_o_1, 8);
    check("drain3_wdata1", wdata_o_1, 32'h63);
    check("drain3_cnt", late_cnt, 1);
    step();
    check("drain_done_cnt", late_cnt, 0);
    check("drain_done_we1", we_o_1, 0);

    // Lane 1 busy, lane 2 idle: entry goes to port 2 only
    lane1(1, 1, 32'h11, 32'h100); lane2(1, 2, 32'h22, 32'h104);
    late(1, 9, 32'h99, 32'h400);
    step();
    late(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    check("p2_cnt", late_cnt, 1);
    step();
    check("p2_we2", we_o_2, 1);
    check("p2_waddr2", waddr_o_2, 9);
    check("p2_wdata2", wdata_o_2, 32'h99);
    check("p2_waddr1", waddr_o_1, 1);
    check("p2_wdata1", wdata_o_1, 32'h11);
    step();
    check("p2_cnt0", late_cnt, 0);
    check("p2_we2_off", we_o_2, 0);

    // Late write to r0 is accepted and dropped
    late(1, 0, 32'hDEAD, 32'h500);
    step();
    late(0, 0, 0, 0);
    check("r0_cnt", late_cnt, 0);
    check("r0_rdy", late_ready, 1);
    check("r0_we2", we_o_2, 0);

    // No same-cycle bypass from an empty queue
    lane1(0, 0, 0, 0); lane2(0, 0, 0, 0);
    step();
    late(1, 10, 32'hA0, 32'h600);
    #1;
    check("nobyp_we1", we_o_1, 0);
    step();
    late(0, 0, 0, 0);
    check("byp_we1", we_o_1, 1);
    check("byp_waddr1", waddr_o_1, 10);
    check("byp_cnt", late_cnt, 1);
    step();
    check("byp_cnt0", late_cnt, 0);
    check("byp_we1_off", we_o_1, 0);

    // Reset with a full queue
    lane1(1, 1, 32'h11, 32'h100); lane2(1, 2, 32'h22, 32'h104);
    late(1, 11, 32'hB1, 32'h700);
    step();
    late(1, 12, 32'hB2, 32'h704);
    step();
    check("pre_rst_cnt", late_cnt, 2);
    rst = 1'b1;
    late(1, 13, 32'hB3, 32'h708);
    step();
    check("mid_rst_cnt", late_cnt, 0);
    check("mid_rst_rdy", late_ready, 1);
    check("mid_rst_we1", we_o_1, 0);
    check("mid_rst_we2", we_o_2, 0);
    check("mid_rst_pc1", pc_o_1, 0);
    check("mid_rst_commit", commit_cnt, 0);
    rst = 1'b0;
    lane1(0, 0, 0, 0); lane2(0, 0, 0, 0); late(0, 0, 0, 0);
    step();
    check("post_rst_cnt", late_cnt, 0);
    check("post_rst_we1", we_o_1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, the late-result queue depth in entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports valid_i_1 / valid_i_2, input, 1 bit each: the memory-stage lane result is valid.
REQ-005 SHALL have ports pc_i_1 / pc_i_2, input, 32 bits each; we_i_1 / we_i_2, input, 1 bit each; waddr_i_1 / waddr_i_2, input, 5 bits each; wdata_i_1 / wdata_i_2, input, 32 bits each: the lane write requests.
REQ-006 SHALL have port flush, input, 1 bit: discard the lane results presented this cycle.
REQ-007 SHALL have ports late_valid, input, 1 bit; late_pc, input, 32 bits; late_waddr, input, 5 bits; late_wdata, input, 32 bits: the long-latency (divider) result.
REQ-008 SHALL have port late_ready, output, 1 bit: the late-result queue can accept an entry.
REQ-009 SHALL have ports pc_o_1 / pc_o_2, output, 32 bits each; we_o_1 / we_o_2, output, 1 bit each; waddr_o_1 / waddr_o_2, output, 5 bits each; wdata_o_1 / wdata_o_2, output, 32 bits each: the register-file write ports.
REQ-010 SHALL have port late_cnt, output, 2 bits: the late-queue occupancy.
REQ-011 SHALL have port commit_cnt, output, 32 bits: the retired-lane counter.

Function
REQ-012 Each lane SHALL be registered (1-cycle latency) and capture {pc, waddr, wdata, we = valid_i & we_i & (waddr_i != 0)}.
REQ-013 When flush=1, both lanes SHALL capture we=0 (a bubble) on the next edge; flush SHALL NOT affect the late queue.
REQ-014 The late queue SHALL be a FIFO that pushes when late_valid & late_ready.
REQ-015 late_ready SHALL be registered-count based (count < FIFO_DEPTH); when full, a same-cycle pop SHALL NOT raise late_ready.
REQ-016 Drain rule, evaluated combinationally on the registered lane state:
- Queue non-empty and lane-1 we=0 -> drive the head onto port 1 with we_o_1=1, pc_o_1=head pc; pop.
- Otherwise, queue non-empty and lane-2 we=0 -> drive the head onto port 2; pop.
- At most one pop per cycle.
REQ-017 When not driven by a lane or the queue, a port SHALL output we=0, and pc, waddr and wdata of 0.
REQ-018 A simultaneous push and pop SHALL leave the count unchanged; an empty queue with a push SHALL NOT bypass the entry to the outputs in the same cycle.
REQ-019 A late entry with waddr=0 SHALL be dropped at push (accepted, not queued).
REQ-020 commit_cnt SHALL add the number of registered lanes with valid=1 (0..2) each cycle, wrapping modulo 2^32; flushed lanes SHALL NOT count.
REQ-021 The two output ports SHALL never carry the same queue entry.

Reset
REQ-022 rst=1 SHALL clear both lane registers (we=0, pc/waddr/wdata=0), empty the queue (late_cnt=0, late_ready=1), and zero commit_cnt.
REQ-023 rst SHALL take priority over flush, push and pop; entries queued before a mid-operation reset SHALL be lost.

Structure
REQ-024 InstAddrBus, RegAddrBus, RegBus widths, WriteEnable and ZeroWord SHALL come from the shared defines file.
REQ-025 The late queue SHALL be a sub-module, sync_fifo (parameters WIDTH=69, DEPTH), exposing full, empty and count.

Verification
REQ-026 Lane 1 {pc=0x1c000000, waddr=3, wdata=0xAA} and lane 2 {waddr=0} -> next cycle we_o_1=1 with waddr 3 and wdata 0xAA, we_o_2=0, and commit_cnt +2.
REQ-027 flush=1 while both lanes are valid -> next cycle we_o_1=we_o_2=0 and commit_cnt unchanged.
REQ-028 Late push {waddr=5, wdata=0x55} while both lanes write every cycle -> held in the queue with late_cnt=1; the first cycle lane 1 idles, port 1 carries waddr 5, and late_cnt returns to 0.
REQ-029 Three back-to-back late pushes with both lanes busy -> late_ready=0 after 2, the third is held upstream, and the entries drain in order 1, 2, 3.
REQ-030 Lane 1 busy, lane 2 idle, queue holds one entry -> the entry is driven on port 2 only.
REQ-031 rst asserted with late_cnt=2 -> next cycle late_cnt=0, late_ready=1, all we_o=0, commit_cnt=0.
